// File: rtl/tlc_pkg.sv
// Shared definitions for the multi-phase traffic controller.
//   - tlc_state_e : controller state (all-red clearance, green, yellow)
//   - LAMP_*      : 2-bit lamp driver codes (11 is never driven)
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } tlc_state_e;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

endpackage

// File: rtl/tlc_rr_select.sv
// Combinational round-robin next-phase picker.
//   req_i          : per-phase vehicle requests
//   active_phase_i : phase served last
//   preempt_i      : emergency preempt, forces phase 0
//   next_phase_o   : phase to turn green next
// Search order is active+1 .. active+NUM_PHASES-1 (mod NUM_PHASES); the
// active phase itself is only chosen when nobody else is waiting, and with
// no requests at all the intersection rests on phase 0.
module tlc_rr_select #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = 2
) (
    input  logic [NUM_PHASES-1:0] req_i,
    input  logic [PH_W-1:0]       active_phase_i,
    input  logic                  preempt_i,
    output logic [PH_W-1:0]       next_phase_o
);

    logic            found;
    logic [PH_W-1:0] idx;

    always_comb begin
        next_phase_o = '0;
        found        = 1'b0;
        idx          = '0;
        for (int i = 1; i < NUM_PHASES; i++) begin
            idx = PH_W'((int'(active_phase_i) + i) % NUM_PHASES);
            if (!found && req_i[idx]) begin
                next_phase_o = idx;
                found        = 1'b1;
            end
        end
        if (!found && req_i[active_phase_i]) next_phase_o = active_phase_i;
        if (preempt_i) next_phase_o = '0;
    end

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// N-phase intersection controller: one approach green at a time, served
// round-robin, with min/max green, fixed yellow, all-red clearance and an
// emergency preempt that rests the intersection on phase 0.
//   clk          : clock
//   clear_n      : async active-low reset (restarts from all-red)
//   req          : per-phase vehicle requests (level)
//   preempt      : emergency request for phase 0, held while high
//   light        : light[2p+1:2p] lamp of phase p (RED 00, YELLOW 01, GREEN 10)
//   active_phase : phase currently green/yellow, last served during all-red
//   green_start  : one-cycle pulse on the first green cycle of any phase
// All outputs decode registered state only, so there is no req->light path.
module multi_phase_traffic_controller
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES   = 4,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 12,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int CNT_W        = 4,
    localparam int PH_W        = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic [NUM_PHASES-1:0]   req,
    input  logic                    preempt,
    output logic [2*NUM_PHASES-1:0] light,
    output logic [PH_W-1:0]         active_phase,
    output logic                    green_start
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);

    tlc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [PH_W-1:0]  next_phase;
    logic             own_req, other_req, green_exit;

    tlc_rr_select #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_rr (
        .req_i          (req),
        .active_phase_i (phase_q),
        .preempt_i      (preempt),
        .next_phase_o   (next_phase)
    );

    assign own_req   = req[phase_q];
    assign other_req = |(req & ~(NUM_PHASES'(1) << phase_q));

    // Preempt cuts any non-zero green short, even inside min green. Without
    // preempt a green only yields when someone else waits, and then either
    // its own queue is empty or it has used up its max green.
    assign green_exit = (preempt && (phase_q != '0)) ||
                        (!preempt && (cnt_q >= MIN_LAST) && other_req &&
                         (!own_req || (cnt_q >= MAX_LAST)));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_ALL_RED;
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        // Saturating timer; every state change below reloads it with 0.
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            ST_ALL_RED: begin
                if (cnt_q == AR_LAST) begin
                    state_d = ST_GREEN;
                    phase_d = next_phase;
                    cnt_d   = '0;
                end
            end
            ST_GREEN: begin
                if (green_exit) begin
                    state_d = ST_YELLOW;
                    cnt_d   = '0;
                end
            end
            ST_YELLOW: begin
                // Yellow is never aborted; a preempt simply waits it out.
                if (cnt_q == Y_LAST) begin
                    state_d = ST_ALL_RED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        light = '0;
        case (state_q)
            ST_GREEN:  light[{phase_q, 1'b0} +: 2] = LAMP_GREEN;
            ST_YELLOW: light[{phase_q, 1'b0} +: 2] = LAMP_YELLOW;
            default:   light = '0;
        endcase
    end

    assign active_phase = phase_q;
    // The timer only reads 0 in green on the entry cycle (it saturates high).
    assign green_start  = (state_q == ST_GREEN) && (cnt_q == '0);

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
module tb_multi_phase_traffic_controller;

    localparam int N    = 4;
    localparam int MIN  = 4;
    localparam int MAXG = 12;
    localparam int Y    = 3;
    localparam int AR   = 2;
    localparam int CW   = 4;
    localparam int PW   = 2;

    logic           clk = 1'b0;
    logic           clear_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic           preempt = 1'b0;
    logic [2*N-1:0] light;
    logic [PW-1:0]  active_phase;
    logic           green_start;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_phase_traffic_controller #(
        .NUM_PHASES   (N),
        .MIN_GREEN    (MIN),
        .MAX_GREEN    (MAXG),
        .YELLOW_TIME  (Y),
        .ALL_RED_TIME (AR),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .req          (req),
        .preempt      (preempt),
        .light        (light),
        .active_phase (active_phase),
        .green_start  (green_start)
    );

    // ---------------- reference model ----------------
    // Mode 0 = all red, 1 = green, 2 = yellow. Yellow/all-red count down the
    // cycles still to go; green tracks how long the phase has been green.
    int m_mode, m_left, m_age, m_ph;

    function automatic int pick();
        if (preempt) return 0;
        for (int k = 1; k < N; k++) begin
            int p;
            p = (m_ph + k) % N;
            if (req[p]) return p;
        end
        if (req[m_ph]) return m_ph;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = AR; m_age = 0; m_ph = 0;
    endtask

    task automatic model_step();
        bit other;
        other = 1'b0;
        for (int p = 0; p < N; p++) if (p != m_ph && req[p]) other = 1'b1;
        case (m_mode)
            0: if (m_left == 1) begin m_ph = pick(); m_mode = 1; m_age = 0; end
               else m_left = m_left - 1;
            1: if ((preempt && m_ph != 0) ||
                   (!preempt && m_age >= MIN-1 && other && (!req[m_ph] || m_age >= MAXG-1))) begin
                   m_mode = 2; m_left = Y;
               end else m_age = m_age + 1;
            default: if (m_left == 1) begin m_mode = 0; m_left = AR; end
                     else m_left = m_left - 1;
        endcase
    endtask

    function automatic logic [2*N-1:0] exp_light();
        logic [2*N-1:0] l;
        l = '0;
        if (m_mode == 1) l[2*m_ph +: 2] = 2'b10;
        else if (m_mode == 2) l[2*m_ph +: 2] = 2'b01;
        return l;
    endfunction

    function automatic logic exp_gs();
        return (m_mode == 1) && (m_age == 0);
    endfunction

    // ---------------- safety monitor ----------------
    // Records invariant violations; each test compares the count it saw.
    int             viol = 0;
    int             ar_run = 0;
    logic [2*N-1:0] prev_l = '0;

    always @(negedge clk) begin
        int nonred;
        if (!clear_n) begin
            prev_l = '0;
            ar_run = ar_run + 1;
        end else begin
            nonred = 0;
            for (int p = 0; p < N; p++) begin
                if (light[2*p +: 2] != 2'b00) nonred = nonred + 1;
                if (light[2*p +: 2] == 2'b11) viol = viol + 1;
                if (prev_l[2*p +: 2] == 2'b10 && light[2*p +: 2] == 2'b00) viol = viol + 1;
                if (prev_l[2*p +: 2] == 2'b00 && light[2*p +: 2] == 2'b10 && ar_run < AR) viol = viol + 1;
            end
            if (nonred > 1) viol = viol + 1;
            ar_run = (light == '0) ? ar_run + 1 : 0;
            prev_l = light;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (clear_n) model_step();
        #1;
    endtask

    // Reset, release, and run to the first green cycle.
    task automatic do_reset();
        @(posedge clk); #1;
        clear_n = 1'b0;
        model_reset();
        tick(); tick();
        @(negedge clk);
        clear_n = 1'b1;
        repeat (AR) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int v0;
        v0 = viol;
        req = '0; preempt = 1'b0;
        do_reset();
        total++;
        if (light !== 8'h02 || green_start !== 1'b1 || active_phase !== 2'd0) begin
            bad++; $display("FAIL reset_first_green: light=%h gs=%b ap=%0d want 02 1 0", light, green_start, active_phase);
        end
        req = 4'b0100;
        repeat (5) tick();
        total++;
        if (light !== 8'h01) begin
            bad++; $display("FAIL pre_reset_yellow: light=%h want 01", light);
        end
        clear_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (light !== 8'h00 || green_start !== 1'b0 || active_phase !== 2'd0) begin
            bad++; $display("FAIL async_reset: light=%h gs=%b ap=%0d want 00 0 0", light, green_start, active_phase);
        end
        req = '0;
        tick(); tick();
        total++;
        if (light !== 8'h00) begin
            bad++; $display("FAIL reset_hold: light=%h want 00", light);
        end
        @(negedge clk);
        clear_n = 1'b1;
        tick();
        total++;
        if (light !== 8'h00 || green_start !== 1'b0) begin
            bad++; $display("FAIL release_allred: light=%h gs=%b want 00 0", light, green_start);
        end
        tick();
        total++;
        if (light !== 8'h02 || green_start !== 1'b1 || active_phase !== 2'd0) begin
            bad++; $display("FAIL release_green: light=%h gs=%b ap=%0d want 02 1 0", light, green_start, active_phase);
        end
        total++;
        if (viol !== v0) begin
            bad++; $display("FAIL safety_reset: violations=%0d want %0d", viol, v0);
        end
    endtask

    task automatic test_idle();
        int v0, errs;
        v0 = viol; errs = 0;
        req = '0; preempt = 1'b0;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            tick();
            if (light !== 8'h02 || green_start !== 1'b0 || light !== exp_light()) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL idle_hold: bad_cycles=%0d want 0 (last light=%h gs=%b)", errs, light, green_start);
        end
        total++;
        if (viol !== v0) begin
            bad++; $display("FAIL safety_idle: violations=%0d want %0d", viol, v0);
        end
    endtask

    task automatic test_single_req();
        logic [7:0] tbl [9];
        int v0;
        tbl = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h20};
        v0 = viol;
        req = '0; preempt = 1'b0;
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            tick();
            total++;
            if (light !== tbl[c] || light !== exp_light()) begin
                bad++; $display("FAIL single_req_seq[%0d]: light=%h want %h", c, light, tbl[c]);
            end
        end
        total++;
        if (active_phase !== 2'd2 || green_start !== 1'b1) begin
            bad++; $display("FAIL single_req_phase: ap=%0d gs=%b want 2 1", active_phase, green_start);
        end
        total++;
        if (viol !== v0) begin
            bad++; $display("FAIL safety_single: violations=%0d want %0d", viol, v0);
        end
    endtask

    task automatic test_round_robin();
        int seq[$];
        int want_a[4];
        int want_b[4];
        int run, budget, v0;
        want_a = '{0, 2, 0, 2};
        want_b = '{1, 2, 3, 1};
        v0 = viol;
        // Two requesters that keep their own queues busy: max green each.
        req = '0; preempt = 1'b0;
        do_reset();
        req = 4'b0101;
        seq.delete(); seq.push_back(int'(active_phase)); run = 1; budget = 0;
        while (seq.size() < 4 && budget < 200) begin
            tick(); budget++;
            if (green_start) begin
                total++;
                if (run !== MAXG) begin
                    bad++; $display("FAIL max_green_len: got %0d want %0d", run, MAXG);
                end
                run = 1; seq.push_back(int'(active_phase));
            end else if (light[2*active_phase +: 2] == 2'b10) run++;
            total++;
            if (light !== exp_light() || green_start !== exp_gs()) begin
                bad++; $display("FAIL rr_model_a: light=%h gs=%b want %h %b", light, green_start, exp_light(), exp_gs());
            end
        end
        total++;
        if (seq.size() !== 4) begin
            bad++; $display("FAIL rr_a_timeout: greens=%0d want 4", seq.size());
        end
        for (int k = 0; k < seq.size(); k++) begin
            total++;
            if (seq[k] !== want_a[k]) begin
                bad++; $display("FAIL rr_a_order[%0d]: got %0d want %0d", k, seq[k], want_a[k]);
            end
        end
        // Three requesters, wrap-around from 3 back to 1.
        req = 4'b1110;
        do_reset();
        seq.delete(); seq.push_back(int'(active_phase)); budget = 0;
        while (seq.size() < 4 && budget < 200) begin
            tick(); budget++;
            if (green_start) seq.push_back(int'(active_phase));
            total++;
            if (light !== exp_light() || active_phase !== PW'(m_ph)) begin
                bad++; $display("FAIL rr_model_b: light=%h ap=%0d want %h %0d", light, active_phase, exp_light(), m_ph);
            end
        end
        total++;
        if (seq.size() !== 4) begin
            bad++; $display("FAIL rr_b_timeout: greens=%0d want 4", seq.size());
        end
        for (int k = 0; k < seq.size(); k++) begin
            total++;
            if (seq[k] !== want_b[k]) begin
                bad++; $display("FAIL rr_b_order[%0d]: got %0d want %0d", k, seq[k], want_b[k]);
            end
        end
        total++;
        if (viol !== v0) begin
            bad++; $display("FAIL safety_rr: violations=%0d want %0d", viol, v0);
        end
    endtask

    task automatic test_preempt();
        logic [7:0] t1 [6];
        logic [7:0] t2 [6];
        int v0, errs;
        t1 = '{8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h02};
        t2 = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02};
        v0 = viol;
        req = 4'b0100; preempt = 1'b0;
        do_reset();
        total++;
        if (active_phase !== 2'd2 || light !== 8'h20) begin
            bad++; $display("FAIL preempt_setup: ap=%0d light=%h want 2 20", active_phase, light);
        end
        tick();
        preempt = 1'b1; req = 4'b1110;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (light !== t1[c] || light !== exp_light()) begin
                bad++; $display("FAIL preempt_seq[%0d]: light=%h want %h", c, light, t1[c]);
            end
        end
        total++;
        if (active_phase !== 2'd0 || green_start !== 1'b1) begin
            bad++; $display("FAIL preempt_phase0: ap=%0d gs=%b want 0 1", active_phase, green_start);
        end
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (light !== 8'h02) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL preempt_hold: bad_cycles=%0d want 0", errs);
        end
        // Drop preempt: phase 0 yields; re-assert preempt inside yellow.
        preempt = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) preempt = 1'b1;
            total++;
            if (light !== t2[c] || light !== exp_light()) begin
                bad++; $display("FAIL yellow_no_abort[%0d]: light=%h want %h", c, light, t2[c]);
            end
        end
        preempt = 1'b0;
        total++;
        if (viol !== v0) begin
            bad++; $display("FAIL safety_preempt: violations=%0d want %0d", viol, v0);
        end
    endtask

    task automatic test_random();
        int v0, errs;
        v0 = viol; errs = 0;
        req = 4'($urandom_range(0, 15)); preempt = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) preempt = ~preempt;
            if ($urandom_range(0, 499) == 0) begin
                clear_n = 1'b0;
                model_reset();
                tick();
                @(negedge clk);
                clear_n = 1'b1;
            end
            tick();
            total++;
            if (light !== exp_light() || green_start !== exp_gs() || active_phase !== PW'(m_ph)) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL random_cycle%0d: light=%h gs=%b ap=%0d want %h %b %0d",
                             c, light, green_start, active_phase, exp_light(), exp_gs(), m_ph);
            end
        end
        preempt = 1'b0;
        total++;
        if (viol !== v0) begin
            bad++; $display("FAIL safety_random: violations=%0d want %0d", viol, v0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_single_req();
        test_round_robin();
        test_preempt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
